icache_dm: RTL

//   Direct-mapped instruction cache answering the fetch address driven by the pc block.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/icache_dm_if.sv | 26 ++
 rtl/icache_frame_array.sv | 61 ++++++
 rtl/icache_dm.sv | 106 ++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package cpu_types_pkg;

  localparam int WORD_W      = 32;
  localparam int ICACHE_SETS = 16;
  localparam int IDX_W       = $clog2(ICACHE_SETS);
  localparam int TAG_W       = WORD_W - IDX_W - 2;

  typedef logic [WORD_W-1:0] word_t;

  // Fetch address split into tag / frame index / byte offset.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic word_t sat_inc(word_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side handshake of the instruction cache.
interface icache_dm_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  iflush;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  // Cache side.
  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  // Datapath + memory controller side.
  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_frame_array.sv
// Valid/tag/data storage for the one-word frames: async read, one write port,
// global valid clear that takes priority over a same-cycle write.
module icache_frame_array
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output word_t            rdata,
  input  logic             wen,
  input  logic             wset,   // write also marks the frame valid
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  word_t            wdata,
  input  logic             clr
);

  logic [ICACHE_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [ICACHE_SETS];
  logic [TAG_W-1:0]       tag_d  [ICACHE_SETS];
  word_t                  data_q [ICACHE_SETS];
  word_t                  data_d [ICACHE_SETS];

  // Next contents: apply the fill, then let a flush wipe every valid bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wen) begin
      tag_d[widx]  = wtag;
      data_d[widx] = wdata;
      if (wset) valid_d[widx] = 1'b1;
    end
    if (clr) valid_d = '0;
  end

  // Storage registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: tag/data are reset as well so imemload/iaddr never show X; a RAM macro would only reset valid.
      valid_q <= '0;
      for (int i = 0; i < ICACHE_SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-latency hit, one-word fill on miss,
// non-abortable memory request, saturating hit/miss counters.
module icache_dm
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  icache_dm_if.slave  bus,
  output word_t       hit_cnt,
  output word_t       miss_cnt
);

  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;
  logic          flushed_q, flushed_d;   // flush seen during the current fill
  word_t         hit_cnt_q, hit_cnt_d;
  word_t         miss_cnt_q, miss_cnt_d;

  icachef_t         req, miss_f;
  logic             rvalid, hit, wen, wset;
  logic [TAG_W-1:0] rtag;
  word_t            rdata;

  assign req    = icachef_t'(bus.imemaddr);
  assign miss_f = icachef_t'(miss_addr_q);

  icache_frame_array u_frames (
    .CLK   (CLK),
    .nRST  (nRST),
    .ridx  (req.idx),
    .rvalid(rvalid),
    .rtag  (rtag),
    .rdata (rdata),
    .wen   (wen),
    .wset  (wset),
    .widx  (miss_f.idx),
    .wtag  (miss_f.tag),
    .wdata (bus.iload),
    .clr   (bus.iflush)
  );

  assign hit = bus.imemREN & rvalid & (rtag == req.tag) & (state_q == IDLE) & ~bus.iflush;

  // Combinational lookup result toward the datapath.
  always_comb begin
    bus.ihit     = hit;
    bus.imemload = hit ? rdata : '0;
  end

  // Next-state, fill control, memory request and counters.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    flushed_d   = flushed_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    wen         = 1'b0;
    wset        = 1'b0;
    bus.iREN    = 1'b0;
    bus.iaddr   = '0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
        end else if (bus.imemREN && !bus.iflush) begin
          miss_addr_d = {bus.imemaddr[WORD_W-1:2], 2'b00};
          flushed_d   = 1'b0;
          miss_cnt_d  = sat_inc(miss_cnt_q);
          state_d     = FETCH;
        end
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = miss_addr_q;
        if (bus.iflush) flushed_d = 1'b1;
        if (!bus.iwait) begin
          wen     = 1'b1;
          wset    = ~flushed_q & ~bus.iflush;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      flushed_q   <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      flushed_q   <= flushed_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
